uart_rx_byte_fifo: RTL

//  Serial-debug receive front end. Runs on the system clock, oversamples rxd at
//  16x baud, majority-votes each bit and decodes 8N1 frames. Queues bytes in a small

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_rx_byte_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive front end.
// Oversampling points, FSM state codes and the bit-vote helper.
package uart_pkg;

    localparam int OS_RATE = 16;
    localparam int SMP_LO  = 7;
    localparam int SMP_MID = 8;
    localparam int SMP_HI  = 9;
    localparam int OS_LAST = 15;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t STOP  = 3'd3;
    localparam state_t BREAK = 3'd4;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through byte queue.
// Extra pointer MSB separates full from empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage and pointer advance; a pop frees the slot a same-cycle push uses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_byte_fifo.sv
// 8N1 receiver with 16x oversampling and 3-sample majority vote.
// Received bytes are queued and offered on a vld/rdy handshake.
module uart_rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] d_rx,
    output logic       vld_rx,
    input  logic       rdy_rx,
    output logic       frm_err,
    output logic       ovf
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OS_RATE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic          rx_meta;
    logic          rxs;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    smp;
    logic [7:0]    shreg;
    logic          eval;
    logic          vote;
    logic          push;
    logic          full;
    logic          empty;
    state_t        state;
    state_t        state_n;

    assign tick = (div_cnt == DW'(DIV - 1));
    assign eval = tick && (os_cnt == 4'(OS_LAST));
    assign vote = maj3(smp);

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Free-running divider producing the 16x oversample tick
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (tick && !rxs) state_n = START;
            START:   if (eval) state_n = vote ? IDLE : DATA;
            DATA:    if (eval && bit_cnt == 3'd7) state_n = STOP;
            STOP:    if (eval) state_n = vote ? IDLE : BREAK;
            BREAK:   if (tick && rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: push or flag error on the stop-bit evaluation
    always_comb begin
        push    = 1'b0;
        frm_err = 1'b0;
        if (state == STOP && eval) begin
            push    = vote;
            frm_err = !vote;
        end
    end

    // Oversample counter, bit samples, bit counter and shift register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            smp     <= 3'b111;
            shreg   <= '0;
        end else if (tick) begin
            if (state == IDLE) begin
                os_cnt <= rxs ? 4'd0 : 4'd1;
            end else if (state == BREAK) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + 4'd1;
            end
            if (os_cnt == 4'(SMP_LO))  smp[0] <= rxs;
            if (os_cnt == 4'(SMP_MID)) smp[1] <= rxs;
            if (os_cnt == 4'(SMP_HI))  smp[2] <= rxs;
            if (eval && state == START) begin
                bit_cnt <= '0;
            end
            if (eval && state == DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {vote, shreg[7:1]};
            end
        end
    end

    // Sticky overflow when a byte arrives with the queue full and no pop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (push && full && !rdy_rx) begin
            ovf <= 1'b1;
        end
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (shreg),
        .pop   (rdy_rx),
        .rdata (d_rx),
        .full  (full),
        .empty (empty)
    );

    assign vld_rx = !empty;

endmodule
